// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm block: state encoding, field widths,
// and the sentinel hour value that marks a disabled alarm.
package alarm_pkg;

  localparam int unsigned HOURS_W   = 5;
  localparam int unsigned MINUTES_W = 6;
  localparam int unsigned H12_W     = 4;

  localparam logic [HOURS_W-1:0] ALARM_DISABLED_HOUR = HOURS_W'(24);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RINGING  = 2'd1,
    SNOOZING = 2'd2
  } alarm_state_t;

endpackage

// File: rtl/alarm_fmt12.sv
// Combinational 24-hour to 12-hour conversion; the disabled hour maps to all zeros.
// Shared with the time display, so the outputs are left unregistered here.
module alarm_fmt12
  import alarm_pkg::*;
(
  input  logic [HOURS_W-1:0]   hours24,
  input  logic [MINUTES_W-1:0] minutes,
  output logic                 valid_c,
  output logic                 is_pm_c,
  output logic [H12_W-1:0]     hours12_c,
  output logic [MINUTES_W-1:0] minutes12_c
);

  always_comb begin
    valid_c     = 1'b0;
    is_pm_c     = 1'b0;
    hours12_c   = '0;
    minutes12_c = '0;
    if (hours24 != ALARM_DISABLED_HOUR) begin
      valid_c     = 1'b1;
      minutes12_c = minutes;
      if (hours24 == HOURS_W'(0)) begin
        hours12_c = H12_W'(12);
      end else if (hours24 < HOURS_W'(12)) begin
        hours12_c = H12_W'(hours24);
      end else if (hours24 == HOURS_W'(12)) begin
        hours12_c = H12_W'(12);
        is_pm_c   = 1'b1;
      end else begin
        hours12_c = H12_W'(hours24 - HOURS_W'(12));
        is_pm_c   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_trigger.sv
// Alarm match detection, ring/snooze/dismiss sequencing and registered 12-hour readback.
// Snooze support is built only when ALARM_SNOOZE_EN is defined; otherwise snooze acts as dismiss.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_1hz,
  input  logic [HOURS_W-1:0]   alarm_hours,
  input  logic [MINUTES_W-1:0] alarm_minutes,
  input  logic [HOURS_W-1:0]   cur_hours,
  input  logic [MINUTES_W-1:0] cur_minutes,
  input  logic                 snooze,
  input  logic                 dismiss,
  output logic                 ring,
  output logic                 snoozing,
  output logic [1:0]           snooze_count,
  output logic                 alarm_valid,
  output logic                 alarm12_isPM,
  output logic [H12_W-1:0]     alarm12_hours,
  output logic [MINUTES_W-1:0] alarm12_minutes
);

  localparam int unsigned RING_W = 8;
  localparam int unsigned SNZ_W  = 9;

  if (RING_SECS < 1 || RING_SECS > 255 || SNOOZE_SECS < 1 || SNOOZE_SECS > 511 ||
      MAX_SNOOZE > 3) begin : g_bad_cfg
    $error("alarm_trigger: parameter out of range");
  end

  alarm_state_t      state;
  logic [RING_W-1:0] ring_cnt;
  logic              eq_q;
  logic              disabled_c;
  logic              equal_c;
  logic              match_c;

  logic                 fmt_valid_c;
  logic                 fmt_pm_c;
  logic [H12_W-1:0]     fmt_hours_c;
  logic [MINUTES_W-1:0] fmt_minutes_c;

  assign disabled_c = (alarm_hours == ALARM_DISABLED_HOUR);
  assign equal_c    = !disabled_c && (cur_hours == alarm_hours) && (cur_minutes == alarm_minutes);
  assign match_c    = equal_c && !eq_q;

  alarm_fmt12 u_fmt12 (
    .hours24     (alarm_hours),
    .minutes     (alarm_minutes),
    .valid_c     (fmt_valid_c),
    .is_pm_c     (fmt_pm_c),
    .hours12_c   (fmt_hours_c),
    .minutes12_c (fmt_minutes_c)
  );

  // Registered readback of the stored alarm for the display path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_valid     <= 1'b0;
      alarm12_isPM    <= 1'b0;
      alarm12_hours   <= '0;
      alarm12_minutes <= '0;
    end else begin
      alarm_valid     <= fmt_valid_c;
      alarm12_isPM    <= fmt_pm_c;
      alarm12_hours   <= fmt_hours_c;
      alarm12_minutes <= fmt_minutes_c;
    end
  end

`ifdef ALARM_SNOOZE_EN
  logic [SNZ_W-1:0] snz_cnt;

  // Priority inside each state: disabled > dismiss > snooze > tick expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ring_cnt     <= '0;
      snz_cnt      <= '0;
      eq_q         <= 1'b0;
      ring         <= 1'b0;
      snoozing     <= 1'b0;
      snooze_count <= '0;
    end else begin
      eq_q <= equal_c;
      if (disabled_c) begin
        state        <= IDLE;
        ring         <= 1'b0;
        snoozing     <= 1'b0;
        snooze_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (match_c) begin
              state        <= RINGING;
              ring         <= 1'b1;
              ring_cnt     <= '0;
              snooze_count <= '0;
            end
          end
          RINGING: begin
            if (dismiss) begin
              state <= IDLE;
              ring  <= 1'b0;
            end else if (snooze) begin
              ring <= 1'b0;
              if (snooze_count < 2'(MAX_SNOOZE)) begin
                state        <= SNOOZING;
                snoozing     <= 1'b1;
                snz_cnt      <= '0;
                snooze_count <= snooze_count + 2'd1;
              end else begin
                state <= IDLE;
              end
            end else if (tick_1hz) begin
              if (ring_cnt == RING_W'(RING_SECS - 1)) begin
                state <= IDLE;
                ring  <= 1'b0;
              end else begin
                ring_cnt <= ring_cnt + RING_W'(1);
              end
            end
          end
          SNOOZING: begin
            if (dismiss) begin
              state    <= IDLE;
              snoozing <= 1'b0;
            end else if (tick_1hz) begin
              if (snz_cnt == SNZ_W'(SNOOZE_SECS - 1)) begin
                state    <= RINGING;
                ring     <= 1'b1;
                snoozing <= 1'b0;
                ring_cnt <= '0;
              end else begin
                snz_cnt <= snz_cnt + SNZ_W'(1);
              end
            end
          end
          default: begin
            state    <= IDLE;
            ring     <= 1'b0;
            snoozing <= 1'b0;
          end
        endcase
      end
    end
  end
`else
  assign snoozing     = 1'b0;
  assign snooze_count = '0;

  // Without snooze support the snooze button is just another dismiss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ring_cnt <= '0;
      eq_q     <= 1'b0;
      ring     <= 1'b0;
    end else begin
      eq_q <= equal_c;
      if (disabled_c) begin
        state <= IDLE;
        ring  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (match_c) begin
              state    <= RINGING;
              ring     <= 1'b1;
              ring_cnt <= '0;
            end
          end
          RINGING: begin
            if (dismiss || snooze) begin
              state <= IDLE;
              ring  <= 1'b0;
            end else if (tick_1hz) begin
              if (ring_cnt == RING_W'(RING_SECS - 1)) begin
                state <= IDLE;
                ring  <= 1'b0;
              end else begin
                ring_cnt <= ring_cnt + RING_W'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
            ring  <= 1'b0;
          end
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_alarm_trigger.sv
// Scoreboard bench for alarm_trigger: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them. Snooze checks follow ALARM_SNOOZE_EN.
module tb_alarm_trigger;
  import alarm_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 tick_1hz;
  logic [HOURS_W-1:0]   alarm_hours;
  logic [MINUTES_W-1:0] alarm_minutes;
  logic [HOURS_W-1:0]   cur_hours;
  logic [MINUTES_W-1:0] cur_minutes;
  logic                 snooze;
  logic                 dismiss;
  logic                 ring;
  logic                 snoozing;
  logic [1:0]           snooze_count;
  logic                 alarm_valid;
  logic                 alarm12_isPM;
  logic [H12_W-1:0]     alarm12_hours;
  logic [MINUTES_W-1:0] alarm12_minutes;

  alarm_trigger #(.RING_SECS(60), .SNOOZE_SECS(300), .MAX_SNOOZE(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .tick_1hz        (tick_1hz),
    .alarm_hours     (alarm_hours),
    .alarm_minutes   (alarm_minutes),
    .cur_hours       (cur_hours),
    .cur_minutes     (cur_minutes),
    .snooze          (snooze),
    .dismiss         (dismiss),
    .ring            (ring),
    .snoozing        (snoozing),
    .snooze_count    (snooze_count),
    .alarm_valid     (alarm_valid),
    .alarm12_isPM    (alarm12_isPM),
    .alarm12_hours   (alarm12_hours),
    .alarm12_minutes (alarm12_minutes)
  );

  always #5 clk = ~clk;

  // fmt=0: a=ring, b=snoozing, c=snooze_count; fmt=1: a=valid, b=isPM, c=hours12, d=minutes
  typedef struct {
    string      name;
    bit         fmt;
    logic       a;
    logic       b;
    logic [3:0] c;
    logic [5:0] d;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    logic [15:0] req;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      if (e.fmt) begin
        act = {4'b0, alarm_valid, alarm12_isPM, alarm12_hours, alarm12_minutes};
        req = {4'b0, e.a, e.b, e.c, e.d};
      end else begin
        act = {13'b0, ring, snoozing, snooze_count};
        req = {13'b0, e.a, e.b, e.c[1:0]};
      end
      n_checks++;
      if (act !== req) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, req, $time);
      end
    end
  end

  task automatic push_fsm(input string name, input logic r, input logic s, input int cnt);
    exp_t e;
    e.name = name; e.fmt = 1'b0; e.a = r; e.b = s; e.c = 4'(cnt); e.d = '0;
    sbq.push_back(e);
  endtask

  task automatic push_fmt(input string name, input logic v, input logic pm, input int h, input int m);
    exp_t e;
    e.name = name; e.fmt = 1'b1; e.a = v; e.b = pm; e.c = 4'(h); e.d = 6'(m);
    sbq.push_back(e);
  endtask

  // Drive one cycle of pulses from a negedge; returns 1 time unit after the posedge.
  task automatic step(input logic t, input logic s, input logic d);
    @(negedge clk);
    tick_1hz = t; snooze = s; dismiss = d;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; snooze = 1'b0; dismiss = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_alarm(input int h, input int m);
    alarm_hours = 5'(h); alarm_minutes = 6'(m);
  endtask

  task automatic set_time(input int h, input int m);
    cur_hours = 5'(h); cur_minutes = 6'(m);
  endtask

  // Leave the alarm minute and come back, producing a fresh match event.
  task automatic retrigger();
    set_time(7, 31); step(1'b0, 1'b0, 1'b0);
    set_time(7, 30); step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    set_alarm(24, 0); set_time(3, 0);
    repeat (3) @(posedge clk);
    #1;
    push_fsm("reset_fsm", 1'b0, 1'b0, 0);
    push_fmt("reset_fmt", 1'b0, 1'b0, 0, 0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // 12-hour readback
    set_alarm(0, 5);   step(1'b0, 1'b0, 1'b0); push_fmt("fmt_0005", 1'b1, 1'b0, 12, 5);
    set_alarm(12, 0);  step(1'b0, 1'b0, 1'b0); push_fmt("fmt_1200", 1'b1, 1'b1, 12, 0);
    set_alarm(23, 59); step(1'b0, 1'b0, 1'b0); push_fmt("fmt_2359", 1'b1, 1'b1, 11, 59);
    set_alarm(13, 15); step(1'b0, 1'b0, 1'b0); push_fmt("fmt_1315", 1'b1, 1'b1, 1, 15);
    set_alarm(11, 45); push_fmt("fmt_latency", 1'b1, 1'b1, 1, 15);
    step(1'b0, 1'b0, 1'b0); push_fmt("fmt_1145", 1'b1, 1'b0, 11, 45);
    set_alarm(24, 0);  step(1'b0, 1'b0, 1'b0); push_fmt("fmt_disabled", 1'b0, 1'b0, 0, 0);
    set_alarm(7, 30);  step(1'b0, 1'b0, 1'b0); push_fmt("fmt_0730", 1'b1, 1'b0, 7, 30);
    push_fsm("idle_no_match", 1'b0, 1'b0, 0);

    // Match, latency and auto-stop after 60 ticks
    set_time(7, 29); step(1'b0, 1'b0, 1'b0); push_fsm("pre_match", 1'b0, 1'b0, 0);
    set_time(7, 30); push_fsm("ring_latency", 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0); push_fsm("ring_rise", 1'b1, 1'b0, 0);
    ticks(59); push_fsm("ring_59_ticks", 1'b1, 1'b0, 0);
    ticks(1);  push_fsm("ring_expire", 1'b0, 1'b0, 0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    push_fsm("held_no_rering", 1'b0, 1'b0, 0);

    // Direct set onto the alarm minute, dismiss while held, re-entry
    set_time(3, 0);  step(1'b0, 1'b0, 1'b0);
    set_time(7, 30); step(1'b0, 1'b0, 1'b0); push_fsm("direct_set", 1'b1, 1'b0, 0);
    n_checks++;
    if (ring !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_set_ring: ring=%b at %0t", ring, $time);
    end
    step(1'b0, 1'b0, 1'b1); push_fsm("dismiss", 1'b0, 1'b0, 0);
    n_checks++;
    if (ring !== 1'b0) begin
      n_fail++;
      $display("FAIL dismiss_ring: ring=%b at %0t", ring, $time);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);
    push_fsm("dismiss_held", 1'b0, 1'b0, 0);
    retrigger(); push_fsm("reenter", 1'b1, 1'b0, 0);

    // A second match while ringing must not restart the ring counter
    ticks(10);
    retrigger();
    ticks(49); push_fsm("ignore_match_59", 1'b1, 1'b0, 0);
    ticks(1);  push_fsm("ignore_match_expire", 1'b0, 1'b0, 0);

    // Disabling the alarm while ringing
    set_time(7, 31); step(1'b0, 1'b0, 1'b0);
    set_time(7, 30); step(1'b0, 1'b0, 1'b0); push_fsm("ring_before_disable", 1'b1, 1'b0, 0);
    set_alarm(24, 30); step(1'b0, 1'b0, 1'b0);
    push_fsm("disable_ring", 1'b0, 1'b0, 0);
    push_fmt("disable_fmt", 1'b0, 1'b0, 0, 0);
    set_time(7, 31); set_alarm(7, 30); step(1'b0, 1'b0, 1'b0);

`ifdef ALARM_SNOOZE_EN
    retrigger(); push_fsm("snz_arm", 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0); push_fsm("snooze1", 1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 1'b0); push_fsm("snooze_ignored", 1'b0, 1'b1, 1);
    ticks(299); push_fsm("snz_299", 1'b0, 1'b1, 1);
    ticks(1);   push_fsm("snz_wake1", 1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 1'b0); push_fsm("snooze2", 1'b0, 1'b1, 2);
    ticks(300); push_fsm("snz_wake2", 1'b1, 1'b0, 2);
    step(1'b0, 1'b1, 1'b0); push_fsm("snooze3", 1'b0, 1'b1, 3);
    ticks(300); push_fsm("snz_wake3", 1'b1, 1'b0, 3);
    step(1'b0, 1'b1, 1'b0); push_fsm("snooze4_dismiss", 1'b0, 1'b0, 3);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    push_fsm("count_hold_idle", 1'b0, 1'b0, 3);
    retrigger(); push_fsm("count_clear_match", 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0); push_fsm("snooze_again", 1'b0, 1'b1, 1);
    ticks(300); push_fsm("wake_again", 1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 1'b1); push_fsm("snooze_dismiss_same", 1'b0, 1'b0, 1);
    retrigger(); step(1'b0, 1'b1, 1'b0);
    ticks(5); step(1'b0, 1'b0, 1'b1); push_fsm("dismiss_snoozing", 1'b0, 1'b0, 1);
    retrigger(); step(1'b0, 1'b1, 1'b0); push_fsm("snz_before_disable", 1'b0, 1'b1, 1);
    set_alarm(24, 30); step(1'b0, 1'b0, 1'b0);
    push_fsm("disable_snoozing", 1'b0, 1'b0, 0);
    set_time(7, 31); set_alarm(7, 30); step(1'b0, 1'b0, 1'b0);
`else
    retrigger(); push_fsm("nosnz_arm", 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0); push_fsm("snooze_as_dismiss", 1'b0, 1'b0, 0);
    ticks(5); push_fsm("no_snooze_interval", 1'b0, 1'b0, 0);
`endif

    // Asynchronous reset mid-ring after 17 ticks, then re-fire on release
    retrigger(); ticks(17); push_fsm("pre_reset_ring", 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    n_checks++;
    if (ring !== 1'b0 || snoozing !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_direct: ring=%b snoozing=%b at %0t", ring, snoozing, $time);
    end
    n_checks++;
    if (snooze_count !== 2'd0 || alarm_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_count: count=%0d valid=%b at %0t", snooze_count, alarm_valid, $time);
    end
    push_fsm("reset_async", 1'b0, 1'b0, 0);
    push_fmt("reset_async_fmt", 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    push_fsm("refire_after_reset", 1'b1, 1'b0, 0);
    push_fmt("fmt_after_reset", 1'b1, 1'b0, 7, 30);
    step(1'b0, 1'b0, 1'b1); push_fsm("final_dismiss", 1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    #1;
    if (n_checks < 12) begin
      n_fail++;
      $display("FAIL check_count: only %0d checks evaluated", n_checks);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_trigger.md
# alarm_trigger

Reads back the canonical 24-hour alarm register (hours 0–23, 24 = disabled) written by the alarm-setting logic. It compares the register against the running clock time and drives the ring output through a ring/snooze/dismiss state machine. It also regenerates the 12-hour view of the stored alarm (hour plus AM/PM) for the display path. It sits between the alarm register, the timekeeping counter, the button debouncers and the buzzer/LED drivers.

## Interface
- RING_SECS, 60, ring duration in tick_1hz pulses before auto-stop (1–255)
- SNOOZE_SECS, 300, snooze duration in tick_1hz pulses (1–511)
- MAX_SNOOZE, 3, snoozes allowed per alarm event; the next snooze acts as dismiss
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tick_1hz  in  1  one-clk-wide pulse per second, synchronous to clk
- alarm_hours  in  5  canonical alarm hour, 0–23; 24 = disabled
- alarm_minutes  in  6  canonical alarm minute, 0–59
- cur_hours  in  5  current time hour, 0–23
- cur_minutes  in  6  current time minute, 0–59
- snooze  in  1  one-clk pulse, debounced
- dismiss  in  1  one-clk pulse, debounced
- ring  out  1  alarm sounding
- snoozing  out  1  snooze interval in progress
- snooze_count  out  2  snoozes taken in the current event
- alarm_valid  out  1  alarm_hours != 24
- alarm12_isPM  out  1  12-hour PM flag of the stored alarm
- alarm12_hours  out  4  12-hour hour of the stored alarm, 1–12; 0 when disabled
- alarm12_minutes  out  6  stored alarm minute; 0 when disabled

## Operation
- equal = (alarm_hours != 24) && cur_hours == alarm_hours && cur_minutes == alarm_minutes.
- eq_q registers equal. A match event is equal && !eq_q, a rising edge. Matching therefore fires once per minute-entry, including when the time is set directly onto the alarm minute.
- FSM states: IDLE, RINGING, SNOOZING.
  - IDLE: a match event moves to RINGING, clears ring_cnt and snooze_count.
  - RINGING: ring=1. ring_cnt increments on each tick_1hz. A tick with ring_cnt == RING_SECS-1 moves to IDLE. dismiss moves to IDLE. snooze with snooze_count < MAX_SNOOZE moves to SNOOZING, clears snz_cnt and increments snooze_count. snooze with snooze_count == MAX_SNOOZE moves to IDLE.
  - SNOOZING: snoozing=1, ring=0. snz_cnt increments on each tick_1hz. A tick with snz_cnt == SNOOZE_SECS-1 moves to RINGING and clears ring_cnt. dismiss moves to IDLE. snooze is ignored.
- Priority when events coincide in one cycle: alarm disabled > dismiss > snooze > tick expiry.
- alarm_hours == 24 in any state forces IDLE on the next edge and clears snooze_count.
- A match event in RINGING or SNOOZING is ignored: no restart, no counter change.
- snooze_count holds its value in IDLE until the next match event.
- 12-hour readback, registered:
  - 0 gives 12 AM; 1–11 give h AM; 12 gives 12 PM; 13–23 give h-12 PM.
  - 24 gives hours 0, isPM 0, minutes 0, alarm_valid 0.
- Counter widths: ring_cnt 8 bits, snz_cnt 9 bits. Neither counter wraps, because expiry occurs before terminal count.

## Timing
- Reset values: ring 0, snoozing 0, snooze_count 0, alarm_valid 0, alarm12_isPM 0, alarm12_hours 0, alarm12_minutes 0, eq_q 0, state IDLE, counters 0.
- ring asserts on the clk edge after the cycle in which equal first becomes true. Latency is 1 cycle.
- ring stays high for exactly RING_SECS tick_1hz pulses, counting the first tick after entry. It drops on the edge that samples the expiring tick.
- snooze or dismiss drops ring on the next edge, a 1-cycle response.
- 12-hour readback outputs update 1 cycle after alarm_hours or alarm_minutes change.
- Reset mid-ring or mid-snooze returns all outputs to their reset values asynchronously. If equal is still true at reset release, it re-fires, because eq_q resets to 0.

## Configuration
- ALARM_SNOOZE_EN defined: behaviour as specified above.
- ALARM_SNOOZE_EN undefined:
  - SNOOZING state and snz_cnt are not built.
  - snooze behaves identically to dismiss.
  - snoozing and snooze_count are tied to 0.
  - MAX_SNOOZE and SNOOZE_SECS are unused.

## Structure
- Shared package `alarm_pkg` holds:
  - state enum alarm_state_t (IDLE, RINGING, SNOOZING)
  - constant ALARM_DISABLED_HOUR = 24
  - constants HOURS_W = 5 and MINUTES_W = 6
- One sub-module, `alarm_fmt12`, performs the combinational 24-to-12-hour conversion. It is reusable by the time display, and its outputs are registered in alarm_trigger.

## Test plan
- alarm 07:30, time stepped 07:29 → 07:30 → ring rises 1 cycle later. With RING_SECS=60, it falls on the 60th tick_1hz.
- alarm 00:05 → alarm12_hours=12, isPM=0. Alarm 12:00 → 12 PM. Alarm 23:59 → 11 PM. Alarm hours=24 → alarm_valid=0, alarm12_hours=0.
- Ringing, snooze pulse → ring=0, snoozing=1, snooze_count=1. After 300 ticks → ring=1 again. Fourth snooze with MAX_SNOOZE=3 → IDLE with snooze_count=3.
- snooze and dismiss in the same cycle while RINGING → IDLE, snooze_count unchanged. alarm_hours set to 24 during SNOOZING → IDLE, snooze_count=0.
- Time held at the alarm minute through dismiss → no re-ring until time leaves and re-enters the minute. Time set directly to 07:30 from 03:00 → ring.
- Async reset asserted mid-ring, with 17 ticks elapsed → all outputs 0 immediately. Build without ALARM_SNOOZE_EN: snooze ends ring, snoozing stays 0.
